// File: rtl/addrgen_mem_arbiter_pkg.sv
// Shared defaults and index helpers for the AddressGen memory arbiter slice.
package addrgen_mem_arbiter_pkg;

    localparam int DEF_NUM_PORTS = 2;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_LAT   = 1;

    // Single-step modulo for port indices that never exceed 2*n-1.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/addrgen_rr_arbiter.sv
// Round-robin arbiter: search starts at the registered pointer, pointer moves past the winner.
// Grant is combinational; the pointer only advances when a grant is actually issued.
module addrgen_rr_arbiter
    import addrgen_mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int TAG_W     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_en,
    output logic [NUM_PORTS-1:0] o_gnt,
    output logic [TAG_W-1:0]     o_gnt_idx
);

    logic [TAG_W-1:0] r_ptr;
    logic             w_found;
    int               w_p;

    always_comb begin
        w_found   = 1'b0;
        o_gnt_idx = '0;
        w_p       = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_p = rr_wrap(int'(r_ptr) + k, NUM_PORTS);
            if (!w_found && i_req[w_p]) begin
                w_found   = 1'b1;
                o_gnt_idx = TAG_W'(w_p);
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            o_gnt[p] = i_en && w_found && (o_gnt_idx == TAG_W'(p));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_en && w_found) begin
            r_ptr <= TAG_W'(rr_wrap(int'(o_gnt_idx) + 1, NUM_PORTS));
        end
    end

endmodule

// File: rtl/addrgen_mem_arbiter.sv
// Shares one memory port between NUM_PORTS AddressGen streams through a single registered stage;
// read data is steered back to its requester by a MEM_LAT-deep tag pipeline.
module addrgen_mem_arbiter
    import addrgen_mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_LAT   = DEF_MEM_LAT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    output logic [NUM_PORTS-1:0]          req_ready_o,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_PORTS-1:0]          req_store_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata_i,
    output logic                          mem_valid_o,
    input  logic                          mem_ready_i,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic                          mem_we_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    output logic [NUM_PORTS-1:0]          rdata_valid_o,
    output logic [DATA_W-1:0]             rdata_o,
    output logic                          busy_o
);

    localparam int TAG_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                 w_slot_free;
    logic                 w_handshake;
    logic [NUM_PORTS-1:0] w_gnt;
    logic [TAG_W-1:0]     w_gnt_idx;
    logic                 w_pipe_busy;

    logic                 r_mem_valid;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic                 r_mem_we;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_pipe_vld [MEM_LAT];
    logic [TAG_W-1:0]     r_pipe_tag [MEM_LAT];

    assign w_slot_free = !r_mem_valid || mem_ready_i;
    assign w_handshake = r_mem_valid && mem_ready_i;

    addrgen_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .TAG_W     (TAG_W)
    ) u_rr (
        .i_clk     (clk_i),
        .i_rst_n   (rst_i),
        .i_req     (req_valid_i),
        .i_en      (w_slot_free),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign req_ready_o = w_gnt;

    // Payload only moves when the slot is free, so it holds across a stalled handshake.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_tag       <= '0;
        end else if (w_slot_free) begin
            r_mem_valid <= |w_gnt;
            if (|w_gnt) begin
                r_mem_addr  <= req_addr_i[w_gnt_idx*ADDR_W +: ADDR_W];
                r_mem_we    <= req_store_i[w_gnt_idx];
                r_mem_wdata <= req_wdata_i[w_gnt_idx*DATA_W +: DATA_W];
                r_tag       <= w_gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_tag[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_handshake && !r_mem_we;
            r_pipe_tag[0] <= r_tag;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
        end
    end

    always_comb begin
        rdata_valid_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdata_valid_o[p] = r_pipe_vld[MEM_LAT-1] && (r_pipe_tag[MEM_LAT-1] == TAG_W'(p));
        end
    end

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            w_pipe_busy = w_pipe_busy | r_pipe_vld[i];
        end
    end

    assign mem_valid_o = r_mem_valid;
    assign mem_addr_o  = r_mem_addr;
    assign mem_we_o    = r_mem_we;
    assign mem_wdata_o = r_mem_wdata;
    assign rdata_o     = mem_rdata_i;
    assign busy_o      = r_mem_valid | w_pipe_busy;

endmodule

// File: tb/tb_addrgen_mem_arbiter.sv
// Bench for addrgen_mem_arbiter with four requesters and a three-cycle memory.
module tb_addrgen_mem_arbiter;

    localparam int NP  = 4;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NP-1:0]        req_valid;
    logic [NP-1:0]        req_ready;
    logic [NP*AW-1:0]     req_addr;
    logic [NP-1:0]        req_store;
    logic [NP*DW-1:0]     req_wdata;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [AW-1:0]        mem_addr;
    logic                 mem_we;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;
    logic [NP-1:0]        rdata_valid;
    logic [DW-1:0]        rdata;
    logic                 busy;

    always #5 clk = ~clk;

    addrgen_mem_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_LAT   (LAT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_store_i   (req_store),
        .req_wdata_i   (req_wdata),
        .mem_valid_o   (mem_valid),
        .mem_ready_i   (mem_ready),
        .mem_addr_o    (mem_addr),
        .mem_we_o      (mem_we),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .rdata_valid_o (rdata_valid),
        .rdata_o       (rdata),
        .busy_o        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stimulus for the next cycle
    logic [NP-1:0] s_vld, s_store;
    logic [AW-1:0] s_addr [NP];
    logic [DW-1:0] s_wdata [NP];
    logic          s_mrdy;
    logic [DW-1:0] s_rdata;

    // Reference model: pointer, one-entry stage, list of reads due back at a given cycle
    typedef struct { int port; int due; } rsp_t;
    rsp_t          pend[$];
    int            m_ptr;
    bit            m_sv;
    logic [AW-1:0] m_addr;
    bit            m_we;
    logic [DW-1:0] m_wdata;
    int            m_tag;
    int            cyc;
    int            obs_gnt;
    int            rv_cnt [NP];

    task automatic model_reset();
        pend.delete();
        m_ptr = 0; m_sv = 0; m_addr = '0; m_we = 0; m_wdata = '0; m_tag = 0;
    endtask

    task automatic drive();
        req_valid = s_vld;
        req_store = s_store;
        mem_ready = s_mrdy;
        mem_rdata = s_rdata;
        for (int p = 0; p < NP; p++) begin
            req_addr[p*AW +: AW]  = s_addr[p];
            req_wdata[p*DW +: DW] = s_wdata[p];
        end
    endtask

    task automatic cycle();
        int            win;
        bit            slot_free;
        logic [NP-1:0] exp_rdy, exp_rv;
        @(negedge clk);
        s_rdata = $urandom();
        drive();
        #1;
        while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        slot_free = !m_sv || s_mrdy;
        win = -1;
        if (slot_free)
            for (int k = 0; k < NP; k++)
                if (win < 0 && s_vld[(m_ptr + k) % NP]) win = (m_ptr + k) % NP;
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        exp_rv = '0;
        foreach (pend[i]) if (pend[i].due == cyc) exp_rv[pend[i].port] = 1'b1;

        chk("req_ready", req_ready, exp_rdy);
        chk("mem_valid", mem_valid, m_sv);
        if (m_sv) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("rdata_valid", rdata_valid, exp_rv);
        if (|exp_rv) chk("rdata", rdata, s_rdata);
        chk("busy", busy, m_sv || pend.size() > 0);

        obs_gnt = -1;
        for (int p = 0; p < NP; p++) begin
            if (req_ready[p]) obs_gnt = p;
            rv_cnt[p] += int'(rdata_valid[p]);
        end

        if (m_sv && s_mrdy && !m_we) pend.push_back('{port: m_tag, due: cyc + LAT});
        if (slot_free) begin
            m_sv = (win >= 0);
            if (win >= 0) begin
                m_addr = s_addr[win]; m_we = s_store[win]; m_wdata = s_wdata[win];
                m_tag = win; m_ptr = (win + 1) % NP;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        s_vld = '0;
        s_mrdy = 1'b1;
        repeat (n) cycle();
    endtask

    initial begin
        int g0, g1, c0, c1;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_wdata;
        int exp_seq [4];
        exp_seq[0] = 3; exp_seq[1] = 1; exp_seq[2] = 3; exp_seq[3] = 1;
        s_vld = '0; s_store = '0; s_mrdy = 1'b1; s_rdata = '0;
        for (int p = 0; p < NP; p++) begin s_addr[p] = '0; s_wdata[p] = '0; rv_cnt[p] = 0; end
        drive();
        model_reset();
        cyc = 0;

        #12;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester streaming reads of addresses 0..7
        c0 = rv_cnt[0];
        for (int k = 0; k < 8; k++) begin
            s_vld = 4'b0001; s_store = '0; s_addr[0] = AW'(k); s_mrdy = 1'b1;
            cycle();
            chk("single_gnt", obs_gnt, 0);
        end
        idle(LAT + 2);
        chk("single_rv_count", rv_cnt[0] - c0, 8);

        // Two always-valid requesters share bandwidth evenly
        g0 = 0; g1 = 0;
        for (int k = 0; k < 100; k++) begin
            s_vld = 4'b0011; s_store = NP'($urandom()); s_mrdy = 1'b1;
            for (int p = 0; p < NP; p++) begin s_addr[p] = AW'($urandom()); s_wdata[p] = $urandom(); end
            cycle();
            if (obs_gnt == 0) g0++;
            if (obs_gnt == 1) g1++;
        end
        chk("fair_port0", g0, 50);
        chk("fair_port1", g1, 50);

        // Memory stall: payload frozen, nobody accepted
        s_vld = 4'b0100; s_store = 4'b0100; s_addr[2] = 10'h155; s_wdata[2] = 32'hDEADBEEF; s_mrdy = 1'b1;
        cycle();
        h_addr = mem_addr; h_wdata = mem_wdata;
        s_vld = 4'b1111; s_mrdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_ready", req_ready, 0);
            chk("stall_addr", mem_addr, 10'h155);
            chk("stall_wdata", mem_wdata, 32'hDEADBEEF);
        end
        idle(LAT + 3);

        // Write then read of the same address: only the read returns data
        c0 = rv_cnt[0]; c1 = rv_cnt[1];
        s_vld = 4'b0001; s_store = 4'b0001; s_addr[0] = 10'd3; s_wdata[0] = 32'hA5; s_mrdy = 1'b1;
        cycle();
        s_vld = 4'b0010; s_store = 4'b0000; s_addr[1] = 10'd3;
        cycle();
        idle(LAT + 3);
        chk("mixed_rv_port1", rv_cnt[1] - c1, 1);
        chk("mixed_rv_port0", rv_cnt[0] - c0, 0);

        // Reset with two reads in flight
        c0 = rv_cnt[0]; c1 = rv_cnt[1];
        s_vld = 4'b0010; s_store = '0; s_mrdy = 1'b1;
        cycle();
        s_vld = 4'b0001;
        cycle();
        s_vld = '0;
        cycle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_valid", mem_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rdata_valid", rdata_valid, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(LAT + 2);
        chk("midrst_no_rv0", rv_cnt[0] - c0, 0);
        chk("midrst_no_rv1", rv_cnt[1] - c1, 0);
        s_vld = 4'b0011;
        cycle();
        chk("midrst_first_win", obs_gnt, 0);
        idle(LAT + 2);

        // Pointer at 2 with ports 1 and 3 valid
        s_vld = 4'b0010;
        cycle();
        for (int k = 0; k < 4; k++) begin
            s_vld = 4'b1010;
            cycle();
            chk("rr_order", obs_gnt, exp_seq[k]);
        end
        idle(LAT + 2);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            s_vld   = NP'($urandom());
            s_store = NP'($urandom());
            s_mrdy  = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NP; p++) begin s_addr[p] = AW'($urandom()); s_wdata[p] = $urandom(); end
            cycle();
        end
        idle(LAT + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
